// File: rtl/axis_width_downsizer_if.sv
// AXI4-Stream bundle shared by the wide input and narrow output of the width downsizer.
interface axis_width_downsizer_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH = 1,
    parameter int unsigned USER_WIDTH = 1
);
    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  tready;
    logic                  tvalid;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        input  tready,
        output tvalid, tdata, tkeep, tlast, tid, tdest, tuser
    );

    modport slave (
        output tready,
        input  tvalid, tdata, tkeep, tlast, tid, tdest, tuser
    );
endinterface

// File: rtl/axis_width_downsizer.sv
// Wide-to-narrow AXI4-Stream converter: one wide beat becomes RATIO narrow beats, LSB slice first,
// with trailing null slices of a packet's final beat trimmed so tlast lands on the last data slice.
module axis_width_downsizer #(
    parameter int unsigned DATA_WIDTH_FROM = 64,
    parameter int unsigned DATA_WIDTH_TO   = 16,
    parameter int unsigned TID_WIDTH       = 1,
    parameter int unsigned TDEST_WIDTH     = 1,
    parameter int unsigned TUSER_WIDTH     = 1,
    parameter bit          TID_EN          = 1'b0,
    parameter bit          TDEST_EN        = 1'b0,
    parameter bit          TUSER_EN        = 1'b0
) (
    input  logic                          aclk,
    input  logic                          areset,
    axis_width_downsizer_if.slave         s_axis,
    axis_width_downsizer_if.master        m_axis
);
    localparam int unsigned RATIO     = DATA_WIDTH_FROM / DATA_WIDTH_TO;
    localparam int unsigned KEEP_TO   = DATA_WIDTH_TO / 8;
    localparam int unsigned KEEP_FROM = DATA_WIDTH_FROM / 8;
    localparam int unsigned IDX_W     = (RATIO > 1) ? $clog2(RATIO) : 1;

    generate
        if ((DATA_WIDTH_FROM % DATA_WIDTH_TO) != 0 || (DATA_WIDTH_TO % 8) != 0) begin : g_bad_width
            $error("axis_width_downsizer: DATA_WIDTH_FROM must be a multiple of DATA_WIDTH_TO, which must be a multiple of 8");
        end
    endgenerate

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {EMPTY, SEND} state_t;

    state_t                 state, state_next;
    logic                   run;
    logic [DATA_WIDTH_FROM-1:0] data_q;
    logic [KEEP_FROM-1:0]   keep_q;
    logic                   last_q;
    logic [TID_WIDTH-1:0]   id_q;
    logic [TDEST_WIDTH-1:0] dest_q;
    logic [TUSER_WIDTH-1:0] user_q;
    idx_t                   idx_q, last_idx_q, last_idx_in;
    logic                   final_slice, ready, load;
    logic [DATA_WIDTH_TO-1:0] slice_data;
    logic [KEEP_TO-1:0]     slice_keep;

    // A final beat with no keep bits at all still emits slice 0 so the packet end is never lost.
    always_comb begin
        last_idx_in = idx_t'(RATIO - 1);
        if (s_axis.tlast) begin
            last_idx_in = '0;
            for (int unsigned i = 0; i < RATIO; i++) begin
                if (|s_axis.tkeep[i*KEEP_TO +: KEEP_TO]) last_idx_in = idx_t'(i);
            end
        end
    end

    assign final_slice = (state == SEND) && (idx_q == last_idx_q) && m_axis.tready;
    assign ready       = run && ((state == EMPTY) || final_slice);
    assign load        = s_axis.tvalid && ready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (load) state_next = SEND;
            SEND:    if (final_slice && !load) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            run        <= 1'b0;
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
            id_q       <= '0;
            dest_q     <= '0;
            user_q     <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
        end else begin
            run <= 1'b1;
            if (load) begin
                data_q     <= s_axis.tdata;
                keep_q     <= s_axis.tkeep;
                last_q     <= s_axis.tlast;
                id_q       <= TID_EN   ? s_axis.tid   : '0;
                dest_q     <= TDEST_EN ? s_axis.tdest : '0;
                user_q     <= TUSER_EN ? s_axis.tuser : '0;
                idx_q      <= '0;
                last_idx_q <= last_idx_in;
            end else if (state == SEND && m_axis.tready && idx_q != last_idx_q) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        slice_data = '0;
        slice_keep = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (idx_q == idx_t'(i)) begin
                slice_data = data_q[i*DATA_WIDTH_TO +: DATA_WIDTH_TO];
                slice_keep = keep_q[i*KEEP_TO +: KEEP_TO];
            end
        end
    end

    assign s_axis.tready = ready;
    assign m_axis.tvalid = (state == SEND);
    assign m_axis.tdata  = slice_data;
    assign m_axis.tkeep  = slice_keep;
    assign m_axis.tlast  = last_q && (idx_q == last_idx_q);
    assign m_axis.tid    = id_q;
    assign m_axis.tdest  = dest_q;
    assign m_axis.tuser  = user_q;
endmodule

// File: tb/tb_axis_width_downsizer.sv
// Self-checking bench for axis_width_downsizer: directed cycle table, random backpressure scoreboard, async reset.
module tb_axis_width_downsizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axis_width_downsizer_if #(.DATA_WIDTH(64), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) s_if ();
    axis_width_downsizer_if #(.DATA_WIDTH(16), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) m_if ();
    axis_width_downsizer_if #(.DATA_WIDTH(64), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) s2_if ();
    axis_width_downsizer_if #(.DATA_WIDTH(16), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) m2_if ();

    axis_width_downsizer #(
        .DATA_WIDTH_FROM(64), .DATA_WIDTH_TO(16), .TID_WIDTH(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1),
        .TID_EN(1'b1), .TDEST_EN(1'b0), .TUSER_EN(1'b1)
    ) dut (.aclk(clk), .areset(rst), .s_axis(s_if), .m_axis(m_if));

    // Second instance with tid forwarding disabled sees the same input stream.
    axis_width_downsizer #(
        .DATA_WIDTH_FROM(64), .DATA_WIDTH_TO(16), .TID_WIDTH(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1),
        .TID_EN(1'b0), .TDEST_EN(1'b0), .TUSER_EN(1'b1)
    ) dut2 (.aclk(clk), .areset(rst), .s_axis(s2_if), .m_axis(m2_if));

    assign s2_if.tvalid = s_if.tvalid;
    assign s2_if.tdata  = s_if.tdata;
    assign s2_if.tkeep  = s_if.tkeep;
    assign s2_if.tlast  = s_if.tlast;
    assign s2_if.tid    = s_if.tid;
    assign s2_if.tdest  = s_if.tdest;
    assign s2_if.tuser  = s_if.tuser;
    assign m2_if.tready = m_if.tready;

    typedef struct {
        logic        sv;
        logic [63:0] sd;
        logic [7:0]  sk;
        logic        sl;
        logic        mr;
        logic        e_sr;
        logic        e_mv;
        logic [15:0] e_md;
        logic [1:0]  e_mk;
        logic        e_ml;
    } vec_t;

    typedef struct packed { logic [15:0] d; logic [1:0] k; logic l; } nb_t;
    typedef struct packed { logic [63:0] d; logic [7:0] k; logic l; } wb_t;

    vec_t tbl[$];
    nb_t  exp_q[$];
    wb_t  wide_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic sv, input logic [63:0] sd, input logic [7:0] sk, input logic sl,
                                input logic mr, input logic esr, input logic emv, input logic [15:0] emd,
                                input logic [1:0] emk, input logic eml);
        vec_t v;
        v.sv = sv; v.sd = sd; v.sk = sk; v.sl = sl; v.mr = mr;
        v.e_sr = esr; v.e_mv = emv; v.e_md = emd; v.e_mk = emk; v.e_ml = eml;
        return v;
    endfunction

    task automatic drive_s(input logic sv, input logic [63:0] sd, input logic [7:0] sk, input logic sl);
        s_if.tvalid = sv;
        s_if.tdata  = sd;
        s_if.tkeep  = sk;
        s_if.tlast  = sl;
    endtask

    initial begin
        logic [63:0] B;
        B = 64'h0008_0007_0006_0005;
        s_if.tid = 1'b1; s_if.tdest = 1'b1; s_if.tuser = 1'b1;
        drive_s(1'b0, '0, '0, 1'b0);
        m_if.tready = 1'b0;

        //         sv    sd                       sk     sl    mr    e_sr  e_mv  e_md      e_mk   e_ml
        tbl.push_back(mk(1'b1, 64'h4444_3333_2222_1111, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1111, 2'b11, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h2222, 2'b11, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3333, 2'b11, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'h4444, 2'b11, 1'b1));
        tbl.push_back(mk(1'b1, 64'h0000_0000_00CC_BBAA, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBBAA, 2'b11, 1'b0));
        tbl.push_back(mk(1'b1, 64'h1234_5678_9ABC_DEF0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00CC, 2'b01, 1'b1));
        tbl.push_back(mk(1'b1, 64'h0004_0003_0002_0001, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 16'hDEF0, 2'b00, 1'b1));
        tbl.push_back(mk(1'b1, B,                       8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 2'b11, 1'b0));
        tbl.push_back(mk(1'b1, B,                       8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 2'b11, 1'b0));
        tbl.push_back(mk(1'b1, B,                       8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0003, 2'b11, 1'b0));
        tbl.push_back(mk(1'b1, B,                       8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0004, 2'b11, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, 2'b11, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0006, 2'b11, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0007, 2'b11, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0008, 2'b11, 1'b1));
        tbl.push_back(mk(1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'hAAAA, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'hAAAA, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'hAAAA, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBBBB, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 16'hCCCC, 2'b11, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'hDDDD, 2'b11, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'hDDDD, 2'b11, 1'b0));
        tbl.push_back(mk(1'b0, '0,                      8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0));

        // Reset values, then ready only one cycle after release.
        @(negedge clk);
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_if.tready), 64'd0);
        chk("rst_m_tdata",  64'(m_if.tdata),  64'd0);
        chk("rst_m_tlast",  64'(m_if.tlast),  64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_s_tready", 64'(s_if.tready), 64'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            drive_s(tbl[i].sv, tbl[i].sd, tbl[i].sk, tbl[i].sl);
            m_if.tready = tbl[i].mr;
            @(negedge clk);
            chk($sformatf("vec%0d_s_tready", i), 64'(s_if.tready), 64'(tbl[i].e_sr));
            chk($sformatf("vec%0d_m_tvalid", i), 64'(m_if.tvalid), 64'(tbl[i].e_mv));
            if (tbl[i].e_mv) begin
                chk($sformatf("vec%0d_m_tdata", i), 64'(m_if.tdata), 64'(tbl[i].e_md));
                chk($sformatf("vec%0d_m_tkeep", i), 64'(m_if.tkeep), 64'(tbl[i].e_mk));
                chk($sformatf("vec%0d_m_tlast", i), 64'(m_if.tlast), 64'(tbl[i].e_ml));
                chk($sformatf("vec%0d_side", i), {61'd0, m_if.tid, m_if.tdest, m_if.tuser}, 64'b101);
                chk($sformatf("vec%0d_tid_off", i), 64'(m2_if.tid), 64'd0);
            end
        end

        // Random packets under ~50% output backpressure.
        for (int p = 0; p < 100; p++) begin
            int nb;
            nb = int'($urandom_range(1, 5));
            for (int b = 0; b < nb; b++) begin
                wb_t w;
                int  li;
                w.d = {$urandom, $urandom};
                w.l = (b == nb - 1);
                w.k = w.l ? 8'($urandom_range(0, 255)) : 8'hFF;
                wide_q.push_back(w);
                li = 3;
                if (w.l) begin
                    li = 0;
                    for (int s = 0; s < 4; s++) if (w.k[s*2 +: 2] != 2'b00) li = s;
                end
                for (int s = 0; s <= li; s++) begin
                    nb_t n;
                    n.d = w.d[s*16 +: 16];
                    n.k = w.k[s*2 +: 2];
                    n.l = w.l && (s == li);
                    exp_q.push_back(n);
                end
            end
        end

        fork
            begin : producer
                int guard;
                logic hs;
                guard = 0;
                @(posedge clk); #1;
                for (int w = 0; w < wide_q.size(); w++) begin
                    drive_s(1'b1, wide_q[w].d, wide_q[w].k, wide_q[w].l);
                    do begin
                        @(negedge clk);
                        hs = s_if.tready;
                        @(posedge clk); #1;
                        guard++;
                    end while (!hs && guard < 20000);
                end
                drive_s(1'b0, '0, '0, 1'b0);
            end
            begin : consumer
                int  got, total, cyc;
                logic stalled;
                nb_t saved, cur, e;
                got = 0; cyc = 0; stalled = 1'b0; saved = '0;
                total = exp_q.size();
                @(posedge clk); #1;
                while (got < total && cyc < 20000) begin
                    m_if.tready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    cur = {m_if.tdata, m_if.tkeep, m_if.tlast};
                    if (stalled)
                        chk("stall_hold", {44'd0, m_if.tvalid, cur}, {44'd0, 1'b1, saved});
                    if (m_if.tvalid && m_if.tready) begin
                        e = exp_q.pop_front();
                        chk($sformatf("sb_beat%0d", got), 64'(cur), 64'(e));
                        got++;
                    end
                    stalled = m_if.tvalid && !m_if.tready;
                    saved   = cur;
                    cyc++;
                    if (got < total) begin
                        @(posedge clk); #1;
                    end
                end
                chk("sb_complete", 64'(got), 64'(total));
            end
        join

        // Asynchronous reset in the middle of a wide beat.
        @(posedge clk); #1;
        drive_s(1'b1, 64'h4444_3333_2222_1111, 8'hFF, 1'b1);
        m_if.tready = 1'b1;
        @(posedge clk); #1 drive_s(1'b0, '0, '0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_slice2", 64'(m_if.tdata), 64'h3333);
        #2 rst = 1'b1;
        #1;
        chk("async_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("async_s_tready", 64'(s_if.tready), 64'd0);
        chk("async_m_tdata",  64'(m_if.tdata),  64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rel2_s_tready", 64'(s_if.tready), 64'd0);
        @(posedge clk); #1;
        drive_s(1'b1, 64'h8888_7777_6666_5555, 8'hFF, 1'b1);
        @(negedge clk);
        chk("post_rst_idle", {62'd0, s_if.tready, m_if.tvalid}, 64'b10);
        @(posedge clk); #1 drive_s(1'b0, '0, '0, 1'b0);
        for (int s = 0; s < 4; s++) begin
            logic [15:0] ed;
            ed = 16'h5555 + 16'(s) * 16'h1111;
            @(negedge clk);
            chk($sformatf("post_rst_slice%0d", s), {45'd0, m_if.tvalid, m_if.tlast, m_if.tdata},
                {45'd0, 1'b1, (s == 3), ed});
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("post_rst_done", 64'(m_if.tvalid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_width_downsizer.md
Name: axis_width_downsizer

Overview:
- AXI4-Stream wide-to-narrow data width converter: accepts one DATA_WIDTH_FROM beat and emits RATIO = DATA_WIDTH_FROM/DATA_WIDTH_TO narrow beats, least-significant slice first.
- Counterpart to the equal-width passthrough in the axi_data_width_converter family. Sits between a wide datapath and a narrow sink.
- Trims trailing null slices on the packet's final beat so that tlast lands on the last slice carrying data.

Parameters:
- DATA_WIDTH_FROM, 64: input tdata width in bits. Must be a multiple of DATA_WIDTH_TO.
- DATA_WIDTH_TO, 16: output tdata width in bits. Must be a multiple of 8.
- TID_WIDTH, 1: tid width.
- TDEST_WIDTH, 1: tdest width.
- TUSER_WIDTH, 1: tuser width.
- TID_EN, 0: forward tid when 1; otherwise drive 0.
- TDEST_EN, 0: forward tdest when 1; otherwise drive 0.
- TUSER_EN, 0: forward tuser when 1; otherwise drive 0.

Ports:
- aclk  in  1  clock, rising edge
- areset  in  1  asynchronous active-high reset
- s_axis_tready  out  1  input ready
- s_axis_tvalid  in  1  input valid
- s_axis_tdata  in  DATA_WIDTH_FROM  input data
- s_axis_tkeep  in  DATA_WIDTH_FROM/8  input byte qualifiers
- s_axis_tlast  in  1  end of packet
- s_axis_tid  in  TID_WIDTH  stream id
- s_axis_tdest  in  TDEST_WIDTH  routing
- s_axis_tuser  in  TUSER_WIDTH  user sideband
- m_axis_tready  in  1  output ready
- m_axis_tvalid  out  1  output valid
- m_axis_tdata  out  DATA_WIDTH_TO  output data slice
- m_axis_tkeep  out  DATA_WIDTH_TO/8  slice byte qualifiers
- m_axis_tlast  out  1  last narrow beat of packet
- m_axis_tid  out  TID_WIDTH  copied from the held wide beat
- m_axis_tdest  out  TDEST_WIDTH  copied from the held wide beat
- m_axis_tuser  out  TUSER_WIDTH  copied from the held wide beat

Behaviour:
- Elaboration:
  - Elaboration error if DATA_WIDTH_FROM % DATA_WIDTH_TO != 0 or DATA_WIDTH_TO % 8 != 0.
  - RATIO == 1 is legal and degenerates to a one-stage register slice.
- Reset: areset asserts asynchronously. Outputs during reset:
  - m_axis_tvalid=0, m_axis_tlast=0, tdata/tkeep/tid/tdest/tuser=0, s_axis_tready=0.
  - Holding register and slice index cleared; an in-flight beat is discarded, not completed.
  - One cycle after deassertion, s_axis_tready=1.
- States:
  - EMPTY: no wide beat held.
  - SEND: wide beat held, slice index idx in 0..RATIO-1.
- EMPTY:
  - s_axis_tready=1, m_axis_tvalid=0.
  - On s_axis_tvalid & tready: capture data, keep, last and sideband; set idx=0; compute last_idx; go to SEND.
- last_idx:
  - If captured tlast=0: last_idx = RATIO-1. All slices are emitted, including slices with zero keep.
  - If tlast=1: last_idx = highest slice index with any nonzero keep bit.
  - If tlast=1 and all keep bits are 0: last_idx = 0, and one beat is emitted with tkeep=0 and tlast=1. The packet end is never dropped.
- SEND:
  - m_axis_tvalid=1.
  - m_axis_tdata = held data[idx*DATA_WIDTH_TO +: DATA_WIDTH_TO]; tkeep is the matching keep slice.
  - m_axis_tlast = held tlast & (idx == last_idx).
  - Sideband is constant for every slice of one wide beat.
  - Outputs are stable while m_axis_tvalid=1 and m_axis_tready=0.
- Advance: on m_axis_tready, if idx < last_idx then idx++.
- Final slice accepted (idx == last_idx & m_axis_tready):
  - If s_axis_tvalid, capture the next wide beat in the same cycle and restart at idx=0. No bubble.
  - Otherwise return to EMPTY.
- s_axis_tready is combinational: EMPTY | (SEND & idx==last_idx & m_axis_tready). There is no combinational path from s_axis_tvalid to any output.
- Latency: wide beat accepted at edge N; first narrow beat valid after edge N (cycle N+1).
- Throughput: one narrow beat per cycle with continuous m_axis_tready.
- Keep is never checked for sparseness inside a beat; null bytes mid-beat pass through unchanged.

Test Plan:
- Reset release, then s beat tdata=64'h4444_3333_2222_1111, tkeep=8'hFF, tlast=1, m_tready=1 -> m beats 16'h1111, 16'h2222, 16'h3333, 16'h4444 on consecutive cycles; tkeep=2'b11 each; tlast only on the 4th.
- tlast beat with tkeep=8'h07 -> exactly 2 m beats; second has tkeep=2'b01 and tlast=1. A tlast beat with tkeep=8'h00 -> one beat with tkeep=0 and tlast=1.
- Two wide beats back-to-back, m_tready=1 throughout -> 8 narrow beats with no gap. s_axis_tready is high in the cycle of the 4th slice handshake.
- Random m_tready backpressure (about 50%) over 100 packets of 1-5 beats with random final keep -> scoreboard byte stream, keep and tlast positions match; outputs stable while stalled.
- TID_EN=1, TUSER_EN=1, tid=1, tuser=1 on a 64-bit beat -> all 4 narrow beats carry tid=1 and tuser=1. With TID_EN=0 -> m_axis_tid=0.
- Assert areset after the 2nd slice is accepted -> m_axis_tvalid=0 immediately (asynchronous). After release, the next packet starts at slice 0 with no residual beats.
